// File: rtl/link_pkg.sv
// link_pkg: shared types and defaults for the inter-board link receiver.
package link_pkg;
  typedef enum logic [1:0] {IDLE, ARM, WAIT_LOW} link_rx_state_t;
  localparam int POWER_W = 5;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STABLE_CYCLES_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 6_000_000;
endpackage

// File: rtl/link_rx_if.sv
// link_rx_if: raw peer pins, filtered outputs and error clear of the link receiver.
interface link_rx_if;
  import link_pkg::*;
  logic [POWER_W-1:0] in_power;
  logic in_throw_flag;
  logic in_player1_ready;
  logic in_player2_ready;
  logic err_clr;
  logic player1_ready;
  logic player2_ready;
  logic throw_valid;
  logic [POWER_W-1:0] throw_power;
  logic link_busy;
  logic link_err;
  modport slave (
    input  in_power, in_throw_flag, in_player1_ready, in_player2_ready, err_clr,
    output player1_ready, player2_ready, throw_valid, throw_power, link_busy, link_err
  );
  modport master (
    output in_power, in_throw_flag, in_player1_ready, in_player2_ready, err_clr,
    input  player1_ready, player2_ready, throw_valid, throw_power, link_busy, link_err
  );
endinterface

// File: rtl/link_sync.sv
// link_sync: N-stage synchroniser with an optional stability filter; all registers reset to 0.
module link_sync
  import link_pkg::*;
#(
  parameter int W = 1,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter logic FILTER_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  if (FILTER_EN) begin : g_filt
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    logic [W-1:0] s, out_q, out_d, cand_q;
    logic [CW-1:0] cnt_q, cnt_d, run;
    // run counts consecutive identical samples that differ from the current output
    always_comb begin
      s = sync_q[SYNC_STAGES-1];
      run = (s == out_q) ? '0 : (s == cand_q && cnt_q != '0) ? cnt_q + 1'b1 : CW'(1);
      out_d = (run == CW'(STABLE_CYCLES)) ? s : out_q;
      cnt_d = (run == CW'(STABLE_CYCLES)) ? '0 : run;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        out_q <= '0;
        cand_q <= '0;
        cnt_q <= '0;
      end else begin
        out_q <= out_d;
        cand_q <= s;
        cnt_q <= cnt_d;
      end
    assign q_o = out_q;
  end else begin : g_raw
    assign q_o = sync_q[SYNC_STAGES-1];
  end
endmodule

// File: rtl/link_rx.sv
// link_rx: synchronises and filters peer link pins, validates throws with a stability handshake.
// Optional watchdog on stuck throws is built when LINK_RX_WATCHDOG_EN is defined.
module link_rx
  import link_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic clk,
  input logic rst_n,
  link_rx_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [POWER_W:0] fp_s;
  logic flag_s, same, err_set;
  logic [POWER_W-1:0] pow_s, prev_q, pow_q, pow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  link_rx_state_t state_q, state_d;
  link_sync #(.W(POWER_W + 1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES), .FILTER_EN(1'b0)) u_fp_sync (
    .clk(clk), .rst_n(rst_n), .d_i({bus.in_throw_flag, bus.in_power}), .q_o(fp_s)
  );
  link_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES), .FILTER_EN(1'b1)) u_p1_sync (
    .clk(clk), .rst_n(rst_n), .d_i(bus.in_player1_ready), .q_o(bus.player1_ready)
  );
  link_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES), .FILTER_EN(1'b1)) u_p2_sync (
    .clk(clk), .rst_n(rst_n), .d_i(bus.in_player2_ready), .q_o(bus.player2_ready)
  );
  assign flag_s = fp_s[POWER_W];
  assign pow_s = fp_s[POWER_W-1:0];
  assign same = pow_s == prev_q;
`ifdef LINK_RX_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd_q <= '0;
    else wd_q <= wd_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    valid_d = 1'b0;
    pow_d = pow_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: state_d = flag_s ? ARM : IDLE;
      ARM: begin
        if (!flag_s) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else if (same && cnt_q == CW'(STABLE_CYCLES - 1)) begin
          valid_d = 1'b1;
          pow_d = pow_s;
          state_d = WAIT_LOW;
        end else cnt_d = same ? cnt_q + 1'b1 : '0;
      end
      WAIT_LOW: state_d = flag_s ? WAIT_LOW : IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LINK_RX_WATCHDOG_EN
    wd_d = (state_q == IDLE) ? '0 : wd_q + 1'b1;
    if (state_q != IDLE && wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
      err_set = 1'b1;
      state_d = WAIT_LOW;
      valid_d = 1'b0;
      pow_d = pow_q;
      cnt_d = '0;
      wd_d = '0;
    end
`endif
    err_d = err_set | (err_q & ~bus.err_clr);
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      prev_q <= '0;
      pow_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      prev_q <= pow_s;
      pow_q <= pow_d;
      valid_q <= valid_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  assign bus.throw_valid = valid_q;
  assign bus.throw_power = pow_q;
  assign bus.link_err = err_q;
  assign bus.link_busy = busy_q;
endmodule

// File: tb/tb_link_rx.sv
// tb_link_rx: directed and randomized checks of link_rx against a pin-level behavioural model.
module tb_link_rx;
  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int TO = 50;
  localparam int LAT = SYNC + STAB + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  link_rx_if bus();
  link_rx #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int edge_n = 0, pulses = 0, pulse_edge = 0, rise = 0, settle = 0, h = 0, err_edge = 0;
  logic [4:0] pulse_pow = '0, prev_pow = '0, p = '0;
  logic exp1 = 1'b0, exp2 = 1'b0, rand_ready = 1'b0;
  logic h1[$], h2[$];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    assert (act === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp_v);
    end
  endtask
  // A ready output takes a pin value once STAB consecutive samples, SYNC edges old, agree on it.
  function automatic logic filt(input logic q[$], input logic cur);
    int b;
    if (q.size() < SYNC + STAB) return cur;
    b = q.size() - 1 - SYNC;
    for (int i = 1; i < STAB; i++) if (q[b-i] !== q[b]) return cur;
    return q[b];
  endfunction
  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      h1.delete();
      h2.delete();
      exp1 = 1'b0;
      exp2 = 1'b0;
      prev_pow = '0;
    end else begin
      h1.push_back(bus.in_player1_ready);
      h2.push_back(bus.in_player2_ready);
      if (h1.size() > 32) void'(h1.pop_front());
      if (h2.size() > 32) void'(h2.pop_front());
      exp1 = filt(h1, exp1);
      exp2 = filt(h2, exp2);
    end
    #1;
    if (bus.throw_valid) begin
      pulses++;
      pulse_edge = edge_n;
      pulse_pow = bus.throw_power;
    end else chk("pow_hold", bus.throw_power, prev_pow);
    prev_pow = bus.throw_power;
    chk("p1_ready", bus.player1_ready, exp1);
    chk("p2_ready", bus.player2_ready, exp2);
    if (rand_ready) begin
      if ($urandom_range(0, 3) == 0) bus.in_player1_ready = ~bus.in_player1_ready;
      if ($urandom_range(0, 3) == 0) bus.in_player2_ready = ~bus.in_player2_ready;
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_p1"}, bus.player1_ready, 0);
    chk({tag, "_p2"}, bus.player2_ready, 0);
    chk({tag, "_valid"}, bus.throw_valid, 0);
    chk({tag, "_power"}, bus.throw_power, 0);
    chk({tag, "_busy"}, bus.link_busy, 0);
    chk({tag, "_err"}, bus.link_err, 0);
  endtask
  initial begin
    bus.in_power = '0;
    bus.in_throw_flag = 1'b0;
    bus.in_player1_ready = 1'b0;
    bus.in_player2_ready = 1'b0;
    bus.err_clr = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    bus.in_power = 5'd19;
    repeat (3) tick();
    pulses = 0;
    bus.in_throw_flag = 1'b1;
    rise = edge_n + 1;
    repeat (20) tick();
    bus.in_throw_flag = 1'b0;
    chk("t1_pulses", pulses, 1);
    chk("t1_edge", pulse_edge, rise + LAT - 1);
    chk("t1_power", pulse_pow, 19);
    chk("t1_err", bus.link_err, 0);
    repeat (SYNC) tick();
    chk("t1_busy_hold", bus.link_busy, 1);
    tick();
    chk("t1_busy_fall", bus.link_busy, 0);
    repeat (3) tick();
    pulses = 0;
    bus.in_throw_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_power = i[0] ? 5'd20 : 5'd19;
      repeat (2) tick();
    end
    bus.in_power = 5'd20;
    settle = edge_n + 1;
    repeat (12) tick();
    bus.in_throw_flag = 1'b0;
    repeat (4) tick();
    chk("tog_pulses", pulses, 1);
    chk("tog_edge", pulse_edge, settle + LAT - 1);
    chk("tog_power", bus.throw_power, 20);
    repeat (2) tick();
    pulses = 0;
    bus.err_clr = 1'b1;
    bus.in_throw_flag = 1'b1;
    repeat (3) tick();
    bus.in_throw_flag = 1'b0;
    repeat (SYNC + 1) tick();
    chk("set_wins", bus.link_err, 1);
    tick();
    chk("clr_held", bus.link_err, 0);
    bus.err_clr = 1'b0;
    repeat (3) tick();
    bus.in_throw_flag = 1'b1;
    repeat (3) tick();
    bus.in_throw_flag = 1'b0;
    repeat (6) tick();
    chk("early_pulses", pulses, 0);
    chk("early_err", bus.link_err, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr", bus.link_err, 0);
    bus.in_player1_ready = 1'b1;
    repeat (2) tick();
    bus.in_player1_ready = 1'b0;
    repeat (8) tick();
    chk("glitch", bus.player1_ready, 0);
    bus.in_player1_ready = 1'b1;
    repeat (SYNC + STAB - 1) tick();
    chk("p1_early", bus.player1_ready, 0);
    tick();
    chk("p1_rise", bus.player1_ready, 1);
    chk("p2_idle", bus.player2_ready, 0);
    pulses = 0;
    bus.in_power = 5'd7;
    bus.in_throw_flag = 1'b1;
    repeat (SYNC + 2) tick();
    chk("arm_busy", bus.link_busy, 1);
    chk("arm_nopulse", pulses, 0);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    prev_pow = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    rise = edge_n + 1;
    repeat (12) tick();
    bus.in_throw_flag = 1'b0;
    repeat (4) tick();
    chk("rearm_pulses", pulses, 1);
    chk("rearm_edge", pulse_edge, rise + LAT - 1);
    chk("rearm_power", pulse_pow, 7);
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      p = (i == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      h = $urandom_range(2, 12);
      bus.in_power = p;
      repeat ($urandom_range(1, 3)) tick();
      pulses = 0;
      bus.in_throw_flag = 1'b1;
      rise = edge_n + 1;
      repeat (h) tick();
      bus.in_throw_flag = 1'b0;
      repeat (6) tick();
      if (h >= LAT - SYNC) begin
        chk("rnd_pulses", pulses, 1);
        chk("rnd_edge", pulse_edge, rise + LAT - 1);
        chk("rnd_power", pulse_pow, p);
        chk("rnd_err", bus.link_err, 0);
      end else begin
        chk("rnd_nopulse", pulses, 0);
        chk("rnd_err_set", bus.link_err, 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("rnd_err_clr", bus.link_err, 0);
      end
    end
    rand_ready = 1'b0;
`ifdef LINK_RX_WATCHDOG_EN
    pulses = 0;
    bus.in_power = 5'd9;
    tick();
    bus.in_throw_flag = 1'b1;
    rise = edge_n + 1;
    err_edge = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.link_err && err_edge == 0) err_edge = edge_n;
    end
    chk("wd_err_edge", err_edge, rise + SYNC + TO);
    chk("wd_pulses", pulses, 1);
    bus.in_throw_flag = 1'b0;
    repeat (SYNC + 2) tick();
    chk("wd_no_pulse", pulses, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    bus.in_throw_flag = 1'b1;
    repeat (12) tick();
    bus.in_throw_flag = 1'b0;
    repeat (4) tick();
    chk("wd_rearm", pulses, 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
